serial_parity_frame_ctrl: RTL
=============================

SERIAL_PARITY_FRAME_CTRL -- requirements
Module: serial_parity_frame_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port serial_input, input, 1, serial bit stream, one bit per clock, data LSB first, then one even-parity bit.
REQ-005 The block SHALL have port start, input, 1, frame-start request.
REQ-006 The block SHALL have port busy, output, 1, high while a frame is being received.
REQ-007 The block SHALL have port frame_valid, output, 1, one-cycle pulse marking a completed frame.
REQ-008 The block SHALL have port data_out, output, DATA_BITS, assembled data of the last completed frame.
REQ-009 The block SHALL have port parity_error, output, 1, parity verdict of the last completed frame (1 = odd total ones).

Function
REQ-010 The FSM SHALL have exactly the states IDLE, DATA, PARITY and DONE.
REQ-011 In IDLE, start=1 SHALL move to DATA and clear the bit counter and running parity; start=0 SHALL stay in IDLE; serial_input in IDLE SHALL be ignored.
REQ-012 In DATA, each cycle SHALL sample serial_input into data bit position [bit counter], XOR it into running parity and increment the counter.
REQ-013 DATA SHALL last exactly DATA_BITS cycles, then move to PARITY.
REQ-014 In PARITY, the single cycle SHALL sample serial_input as the parity bit and move to DONE.
REQ-015 On entry to DONE, data_out SHALL load the assembled word and parity_error SHALL load running parity XOR parity bit.
REQ-016 frame_valid SHALL be high for exactly the one DONE cycle; latency: frame_valid high in the cycle after the parity bit is sampled (DATA_BITS+2 cycles after the start cycle).
REQ-017 In DONE, start=1 SHALL go directly to DATA (back-to-back frames, no IDLE gap); start=0 SHALL go to IDLE.
REQ-018 start SHALL be ignored in DATA and PARITY; an in-progress frame is never restarted.
REQ-019 busy SHALL be high exactly in DATA and PARITY.
REQ-020 data_out and parity_error SHALL hold their values between DONE cycles.
REQ-021 A frame interrupted by reset SHALL produce no frame_valid pulse.

Reset
REQ-022 Asserting reset (low) SHALL immediately, without a clock edge, force IDLE, busy=0, frame_valid=0, data_out=0, parity_error=0, bit counter=0, running parity=0.
REQ-023 After reset release, the first start SHALL be accepted on the next posedge clk.

Configuration
REQ-024 Macro SERIAL_PARITY_ERR_COUNT_EN SHALL, when defined, add output err_count, 8 bits, reset to 0, incremented in each DONE cycle with parity_error=1 and saturating at 255.
REQ-025 Without SERIAL_PARITY_ERR_COUNT_EN, err_count and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification (DATA_BITS=8)
REQ-026 Start, send 0xA5 LSB first, parity 0 -> frame_valid one pulse 10 cycles after start cycle, data_out=0xA5, parity_error=0.
REQ-027 Start, send 0x01, parity 0 -> data_out=0x01, parity_error=1; with macro err_count=1.
REQ-028 Hold start=1 during DONE of frame 0x3C/p0, follow with 0xFF/p1 -> two frame_valid pulses 10 cycles apart, second data_out=0xFF, parity_error=1.
REQ-029 Pulse start during DATA bit 3 -> ignored; frame completes at original timing with correct data.
REQ-030 Drive reset low mid-DATA -> outputs immediately 0, no frame_valid; next frame 0x5A/p0 received correctly.
REQ-031 With macro, 260 errored frames -> err_count=255 and held.

Source files
------------

// File: rtl/serial_parity_frame_ctrl.sv
// Serial frame receiver: DATA_BITS data bits (LSB first) followed by one even-parity bit.
// Define SERIAL_PARITY_ERR_COUNT_EN to add a saturating 8-bit parity error counter (err_count).
module serial_parity_frame_ctrl #(
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 serial_input,
   input  logic                 start,
   output logic                 busy,
   output logic                 frame_valid,
   output logic [DATA_BITS-1:0] data_out,
`ifdef SERIAL_PARITY_ERR_COUNT_EN
   output logic                 parity_error,
   output logic [7:0]           err_count
`else
   output logic                 parity_error
`endif
);

   localparam int unsigned CntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StDone
   } state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 run_par_q, run_par_d;
   logic [DATA_BITS-1:0] word_q, word_d;
   logic                 busy_q, busy_d;
   logic                 frame_valid_q, frame_valid_d;
   logic [DATA_BITS-1:0] data_out_q, data_out_d;
   logic                 parity_error_q, parity_error_d;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      run_par_d      = run_par_q;
      word_d         = word_q;
      frame_valid_d  = 1'b0;
      data_out_d     = data_out_q;
      parity_error_d = parity_error_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StData;
               cnt_d     = '0;
               run_par_d = 1'b0;
            end
         end
         StData: begin
            word_d[cnt_q] = serial_input;
            run_par_d     = run_par_q ^ serial_input;
            cnt_d         = cnt_q + 1'b1;
            if (cnt_q == LastBit) begin
               state_d = StParity;
            end
         end
         StParity: begin
            state_d        = StDone;
            frame_valid_d  = 1'b1;
            data_out_d     = word_q;
            parity_error_d = run_par_q ^ serial_input;
         end
         StDone: begin
            // start held through DONE chains straight into the next frame
            if (start) begin
               state_d   = StData;
               cnt_d     = '0;
               run_par_d = 1'b0;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d == StData) || (state_d == StParity);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         run_par_q      <= 1'b0;
         word_q         <= '0;
         busy_q         <= 1'b0;
         frame_valid_q  <= 1'b0;
         data_out_q     <= '0;
         parity_error_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         run_par_q      <= run_par_d;
         word_q         <= word_d;
         busy_q         <= busy_d;
         frame_valid_q  <= frame_valid_d;
         data_out_q     <= data_out_d;
         parity_error_q <= parity_error_d;
      end
   end

   assign busy         = busy_q;
   assign frame_valid  = frame_valid_q;
   assign data_out     = data_out_q;
   assign parity_error = parity_error_q;

`ifdef SERIAL_PARITY_ERR_COUNT_EN
   logic [7:0] err_count_q, err_count_d;

   always_comb begin
      err_count_d = err_count_q;
      if ((state_q == StDone) && parity_error_q && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_count_q <= 8'd0;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   assign err_count = err_count_q;
`endif

endmodule
